// File: rtl/apsk_symbol_mapper.sv
// apsk_symbol_mapper: gathers serial bits MSB-first into k-bit labels and maps them through a programmable APSK table
module apsk_symbol_mapper #(
    parameter int WL   = 18,
    parameter int FRAC = 10,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      mode_i,
    input  logic            flush_i,
    input  logic            bit_i,
    input  logic            bit_valid_i,
    output logic            bit_ready_o,
    input  logic            lut_we_i,
    input  logic [5:0]      lut_addr_i,
    input  logic [WL-1:0]   lut_re_i,
    input  logic [WL-1:0]   lut_im_i,
    output logic [WL-1:0]   sym_re_o,
    output logic [WL-1:0]   sym_im_o,
    output logic            sym_valid_o,
    input  logic            sym_ready_i,
    output logic [CNTW-1:0] sym_cnt_o
);
    if (FRAC >= WL) begin : g_frac_check
        $error("FRAC must leave at least one integer bit");
    end
    logic [WL-1:0] tab_re [64];
    logic [WL-1:0] tab_im [64];
    logic [2:0]    bit_cnt;
    logic [4:0]    label;
    logic [1:0]    mode_q;
    logic [1:0]    mode_eff;
    logic [2:0]    k;
    logic [4:0]    label_nxt;
    logic [5:0]    base;
    logic [5:0]    addr;
    logic          accept;
    logic          done;
    logic          handoff;
    assign bit_ready_o = !sym_valid_o || sym_ready_i;
    // The first bit of a label uses mode_i directly; later bits use the latched mode.
    always_comb begin
        mode_eff  = (bit_cnt == 3'd0) ? mode_i : mode_q;
        k         = {1'b0, mode_eff} + 3'd2;
        label_nxt = (bit_cnt == 3'd0) ? {4'b0, bit_i} : {label[3:0], bit_i};
        base      = mode_eff == 2'd0 ? 6'd0 : mode_eff == 2'd1 ? 6'd4 : mode_eff == 2'd2 ? 6'd12 : 6'd32;
        addr      = base + {1'b0, label_nxt};
        accept    = bit_valid_i && bit_ready_o && !flush_i;
        done      = accept && (bit_cnt == k - 3'd1);
        handoff   = sym_valid_o && sym_ready_i;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) begin
                tab_re[i] <= '0;
                tab_im[i] <= '0;
            end
            bit_cnt     <= '0;
            label       <= '0;
            mode_q      <= '0;
            sym_cnt_o   <= '0;
            sym_re_o    <= '0;
            sym_im_o    <= '0;
            sym_valid_o <= 1'b0;
        end else begin
            if (lut_we_i) begin
                tab_re[lut_addr_i] <= lut_re_i;
                tab_im[lut_addr_i] <= lut_im_i;
            end
            if (handoff)
                sym_cnt_o <= sym_cnt_o + 1'b1;
            if (flush_i || done) begin
                bit_cnt <= '0;
                label   <= '0;
            end else if (accept) begin
                bit_cnt <= bit_cnt + 3'd1;
                label   <= label_nxt;
            end
            if (accept && bit_cnt == 3'd0)
                mode_q <= mode_i;
            // Table read sees the pre-write contents on a same-edge write.
            if (done) begin
                sym_re_o    <= tab_re[addr];
                sym_im_o    <= tab_im[addr];
                sym_valid_o <= 1'b1;
            end else if (handoff) begin
                sym_valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_apsk_symbol_mapper.sv
// tb_apsk_symbol_mapper: directed and randomized checks of the APSK mapper against a label-queue reference model
module tb_apsk_symbol_mapper;
    localparam int WL   = 18;
    localparam int CNTW = 4;
    localparam int BASE_OF [4] = '{0, 4, 12, 32};
    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      mode;
    logic            flush;
    logic            bit_d;
    logic            bit_v;
    logic            bit_ready;
    logic            lut_we;
    logic [5:0]      lut_addr;
    logic [WL-1:0]   lut_re;
    logic [WL-1:0]   lut_im;
    logic [WL-1:0]   sym_re;
    logic [WL-1:0]   sym_im;
    logic            sym_valid;
    logic            sym_ready;
    logic [CNTW-1:0] sym_cnt;
    int nchk = 0;
    int nfail = 0;
    int q_bits [$];
    int lmode;
    logic            ev;
    logic [WL-1:0]   er;
    logic [WL-1:0]   ei;
    logic [CNTW-1:0] ecnt;
    logic [WL-1:0]   mre [64];
    logic [WL-1:0]   mim [64];
    always #5 clk = ~clk;
    apsk_symbol_mapper #(.WL(WL), .FRAC(10), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n), .mode_i(mode), .flush_i(flush), .bit_i(bit_d),
        .bit_valid_i(bit_v), .bit_ready_o(bit_ready), .lut_we_i(lut_we), .lut_addr_i(lut_addr),
        .lut_re_i(lut_re), .lut_im_i(lut_im), .sym_re_o(sym_re), .sym_im_o(sym_im),
        .sym_valid_o(sym_valid), .sym_ready_i(sym_ready), .sym_cnt_o(sym_cnt)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask
    // One clock: check ready, advance the model with the driven inputs, then check outputs at the next negedge.
    task automatic tick();
        bit rdy, acc, hand, cmp;
        int lbl;
        #1;
        rdy = !ev || sym_ready;
        chk("bit_ready", 32'(bit_ready), 32'(rdy));
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) begin
                mre[i] = '0;
                mim[i] = '0;
            end
            q_bits.delete();
            lmode = 0;
            ev = 1'b0;
            er = '0;
            ei = '0;
            ecnt = '0;
        end else begin
            acc  = bit_v && rdy && !flush;
            hand = ev && sym_ready;
            cmp  = 1'b0;
            if (hand) ecnt++;
            if (flush) q_bits.delete();
            else if (acc) begin
                if (q_bits.size() == 0) lmode = int'(mode);
                q_bits.push_back(int'(bit_d));
                if (q_bits.size() == lmode + 2) begin
                    lbl = 0;
                    foreach (q_bits[i]) lbl = lbl * 2 + q_bits[i];
                    er = mre[BASE_OF[lmode] + lbl];
                    ei = mim[BASE_OF[lmode] + lbl];
                    cmp = 1'b1;
                    q_bits.delete();
                end
            end
            if (cmp) ev = 1'b1;
            else if (hand) ev = 1'b0;
            if (lut_we) begin
                mre[lut_addr] = lut_re;
                mim[lut_addr] = lut_im;
            end
        end
        @(negedge clk);
        chk("sym_valid", 32'(sym_valid), 32'(ev));
        chk("sym_re", 32'(sym_re), 32'(er));
        chk("sym_im", 32'(sym_im), 32'(ei));
        chk("sym_cnt", 32'(sym_cnt), 32'(ecnt));
    endtask
    task automatic send(input logic b);
        bit_v = 1'b1;
        bit_d = b;
        tick();
        bit_v = 1'b0;
    endtask
    task automatic wr(input logic [5:0] a, input logic [WL-1:0] re, input logic [WL-1:0] im);
        lut_we = 1'b1;
        lut_addr = a;
        lut_re = re;
        lut_im = im;
        tick();
        lut_we = 1'b0;
    endtask
    initial begin
        rst_n = 1'b0; mode = 2'd0; flush = 1'b0; bit_d = 1'b0; bit_v = 1'b0;
        lut_we = 1'b0; lut_addr = '0; lut_re = '0; lut_im = '0; sym_ready = 1'b1;
        ev = 1'b0; er = '0; ei = '0; ecnt = '0; lmode = 0;
        @(negedge clk);
        tick();
        tick();
        chk("rst_valid", 32'(sym_valid), 32'd0);
        chk("rst_cnt", 32'(sym_cnt), 32'd0);
        chk("rst_ready", 32'(bit_ready), 32'd1);
        rst_n = 1'b1;
        // QPSK: sign of re from the first bit, sign of im from the second
        for (int a = 0; a < 4; a++)
            wr(a[5:0], a[1] ? 18'h3FD2C : 18'h002D4, a[0] ? 18'h3FD2C : 18'h002D4);
        mode = 2'd0;
        send(1'b1);
        send(1'b0);
        chk("qpsk_re", 32'(sym_re), 32'h3FD2C);
        chk("qpsk_im", 32'(sym_im), 32'h002D4);
        tick();
        chk("qpsk_cnt", 32'(sym_cnt), 32'd1);
        // 32APSK label 10011 with a mid-label mode change
        wr(6'd51, 18'h01234, 18'h3ABCD);
        mode = 2'd3;
        send(1'b1);
        send(1'b0);
        mode = 2'd0;
        send(1'b0);
        send(1'b1);
        send(1'b1);
        chk("apsk32_re", 32'(sym_re), 32'h01234);
        chk("apsk32_im", 32'(sym_im), 32'h3ABCD);
        // Backpressure holds the symbol and blocks bits
        sym_ready = 1'b0;
        bit_v = 1'b1;
        bit_d = 1'b1;
        repeat (10) tick();
        chk("bp_ready", 32'(bit_ready), 32'd0);
        chk("bp_hold", 32'(sym_re), 32'h01234);
        sym_ready = 1'b1;
        tick();
        bit_d = 1'b0;
        tick();
        bit_v = 1'b0;
        chk("bp_resume", 32'(sym_re), 32'h3FD2C);
        // Flush after two 16APSK bits, then a same-edge table write on completion
        wr(6'd18, 18'h00AAA, 18'h00BBB);
        mode = 2'd2;
        send(1'b1);
        send(1'b1);
        flush = 1'b1;
        bit_v = 1'b1;
        tick();
        flush = 1'b0;
        bit_v = 1'b0;
        send(1'b0);
        send(1'b1);
        send(1'b1);
        lut_we = 1'b1; lut_addr = 6'd18; lut_re = 18'h00555; lut_im = 18'h00666;
        send(1'b0);
        lut_we = 1'b0;
        chk("collide_re", 32'(sym_re), 32'h00AAA);
        chk("collide_im", 32'(sym_im), 32'h00BBB);
        tick();
        // Reset mid-label
        mode = 2'd3;
        send(1'b1);
        send(1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_valid", 32'(sym_valid), 32'd0);
        chk("midrst_cnt", 32'(sym_cnt), 32'd0);
        for (int a = 0; a < 64; a++)
            wr(a[5:0], WL'($urandom), WL'($urandom));
        repeat (3000) begin
            mode      = 2'($urandom_range(0, 3));
            bit_v     = ($urandom_range(0, 9) < 8);
            bit_d     = 1'($urandom);
            sym_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 19) == 0);
            lut_we    = ($urandom_range(0, 19) < 3);
            lut_addr  = 6'($urandom);
            lut_re    = WL'($urandom);
            lut_im    = WL'($urandom);
            tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule
